// File: rtl/axi_addr_guard.sv
// axi_addr_guard
//   Address-window guard between a 64-bit AXI master and the DDR address
//   mapper. Transactions whose addr[31:28] matches WIN_TAG pass through with
//   no added latency. Any other address is terminated locally with DECERR,
//   so it can never alias into DRAM through the mapper's truncated decode.
//   A rejected transaction waits until every forwarded transaction in its
//   direction has completed. This keeps local responses from overtaking
//   downstream ones.
//
// Ports
//   clk, reset            single clock, asynchronous active-high reset
//   s_axi_*               upstream slave port (from the core)
//   m_axi_*               downstream master port (to the address mapper)
//   decerr_cnt            saturating count of rejected AW + AR transactions
//   last_bad_addr         address of the most recently rejected AW or AR
//                         (AR wins when both are rejected in one cycle)
module axi_addr_guard #(
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 64,
  parameter int          ID_WIDTH        = 5,
  parameter logic [3:0]  WIN_TAG         = 4'h8,
  parameter int          MAX_OUTSTANDING = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  // upstream write address
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // upstream write data
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // upstream write response
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // upstream read address
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // upstream read data
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // downstream write address
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // downstream write data
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // downstream write response
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // downstream read address
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // downstream read data
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  // debug
  output logic [15:0]             decerr_cnt,
  output logic [ADDR_WIDTH-1:0]   last_bad_addr
);

  typedef enum logic [1:0] {WR_IDLE, WR_PASS, WR_DRAIN, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_ERR}                     rd_state_t;

  localparam logic [3:0] CNT_MAX     = 4'(MAX_OUTSTANDING);
  localparam logic [1:0] RESP_DECERR = 2'b11;

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic [3:0]            wr_cnt;
  logic [3:0]            rd_cnt;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [7:0]            beat_cnt;

  // Window check: only the top nibble is compared; the mapper decodes the rest.
  logic aw_legal, ar_legal;
  assign aw_legal = (s_axi_awaddr[ADDR_WIDTH-1 -: 4] == WIN_TAG);
  assign ar_legal = (s_axi_araddr[ADDR_WIDTH-1 -: 4] == WIN_TAG);

  logic aw_pass, aw_reject, w_pass, w_drain, b_local;
  logic ar_pass, ar_reject, r_local;
  assign aw_pass   = (wr_state == WR_IDLE) && aw_legal && (wr_cnt < CNT_MAX);
  assign aw_reject = (wr_state == WR_IDLE) && s_axi_awvalid && !aw_legal && (wr_cnt == 4'd0);
  assign w_pass    = (wr_state == WR_PASS);
  assign w_drain   = (wr_state == WR_DRAIN);
  assign b_local   = (wr_state == WR_RESP);
  assign ar_pass   = (rd_state == RD_IDLE) && ar_legal && (rd_cnt < CNT_MAX);
  assign ar_reject = (rd_state == RD_IDLE) && s_axi_arvalid && !ar_legal && (rd_cnt == 4'd0);
  assign r_local   = (rd_state == RD_ERR);

  // Payload fields are straight wires; only the handshakes are steered.
  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_awlock  = s_axi_awlock;
  assign m_axi_awcache = s_axi_awcache;
  assign m_axi_awprot  = s_axi_awprot;
  assign m_axi_awqos   = s_axi_awqos;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign m_axi_arlock  = s_axi_arlock;
  assign m_axi_arcache = s_axi_arcache;
  assign m_axi_arprot  = s_axi_arprot;
  assign m_axi_arqos   = s_axi_arqos;

  // NOTE: handshake outputs are also masked by reset. The pass-through paths
  // are combinational, so without the mask a downstream valid could leak
  // upstream while reset is held.
  assign m_axi_awvalid = !reset && aw_pass && s_axi_awvalid;
  assign s_axi_awready = !reset && ((aw_pass && m_axi_awready) || aw_reject);
  assign m_axi_wvalid  = !reset && w_pass && s_axi_wvalid;
  assign s_axi_wready  = !reset && ((w_pass && m_axi_wready) || w_drain);
  assign s_axi_bvalid  = !reset && (b_local || m_axi_bvalid);
  assign s_axi_bid     = b_local ? bid_q : m_axi_bid;
  assign s_axi_bresp   = b_local ? RESP_DECERR : m_axi_bresp;
  assign m_axi_bready  = !reset && !b_local && s_axi_bready;

  assign m_axi_arvalid = !reset && ar_pass && s_axi_arvalid;
  assign s_axi_arready = !reset && ((ar_pass && m_axi_arready) || ar_reject);
  assign s_axi_rvalid  = !reset && (r_local || m_axi_rvalid);
  assign s_axi_rid     = r_local ? rid_q : m_axi_rid;
  assign s_axi_rdata   = r_local ? '0 : m_axi_rdata;
  assign s_axi_rresp   = r_local ? RESP_DECERR : m_axi_rresp;
  assign s_axi_rlast   = r_local ? (beat_cnt == 8'd0) : m_axi_rlast;
  assign m_axi_rready  = !reset && !r_local && s_axi_rready;

  logic m_aw_hs, m_b_hs, s_w_hs, m_ar_hs, m_rlast_hs;
  assign m_aw_hs    = m_axi_awvalid && m_axi_awready;
  assign m_b_hs     = m_axi_bvalid && m_axi_bready;
  assign s_w_hs     = s_axi_wvalid && s_axi_wready;
  assign m_ar_hs    = m_axi_arvalid && m_axi_arready;
  assign m_rlast_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  // Write FSM. A forwarded AW owns the W channel until its wlast, so W data
  // always follows its own AW.
  // NOTE: state is updated with non-blocking assignments only, so every
  // always_ff samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      bid_q    <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (m_aw_hs) begin
            wr_state <= WR_PASS;
          end else if (aw_reject) begin
            bid_q    <= s_axi_awid;
            wr_state <= WR_DRAIN;
          end
        end
        WR_PASS:  if (s_w_hs && s_axi_wlast) wr_state <= WR_IDLE;
        WR_DRAIN: if (s_w_hs && s_axi_wlast) wr_state <= WR_RESP;
        WR_RESP:  if (s_axi_bready)          wr_state <= WR_IDLE;
        default:                             wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read FSM. beat_cnt holds the number of DECERR beats still to be sent
  // after the current one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rid_q    <= '0;
      beat_cnt <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_reject) begin
            rid_q    <= s_axi_arid;
            beat_cnt <= s_axi_arlen;
            rd_state <= RD_ERR;
          end
        end
        RD_ERR: begin
          if (s_axi_rready) begin
            if (beat_cnt == 8'd0) rd_state <= RD_IDLE;
            else                  beat_cnt <= beat_cnt - 8'd1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Outstanding counters for forwarded traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      case ({m_aw_hs, m_b_hs})
        2'b10:   wr_cnt <= wr_cnt + 4'd1;
        2'b01:   wr_cnt <= wr_cnt - 4'd1;
        default: wr_cnt <= wr_cnt;
      endcase
      case ({m_ar_hs, m_rlast_hs})
        2'b10:   rd_cnt <= rd_cnt + 4'd1;
        2'b01:   rd_cnt <= rd_cnt - 4'd1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  // Debug: both directions may reject in one cycle, so the increment is 0..2.
  logic [1:0]  rej_inc;
  logic [16:0] decerr_sum;
  assign rej_inc    = {1'b0, aw_reject} + {1'b0, ar_reject};
  assign decerr_sum = {1'b0, decerr_cnt} + 17'(rej_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decerr_cnt    <= '0;
      last_bad_addr <= '0;
    end else begin
      decerr_cnt <= decerr_sum[16] ? 16'hFFFF : decerr_sum[15:0];
      if (ar_reject)      last_bad_addr <= s_axi_araddr;
      else if (aw_reject) last_bad_addr <= s_axi_awaddr;
    end
  end

endmodule

// File: doc/axi_addr_guard.md
Name: axi_addr_guard

Overview:
- Sits directly upstream of the zedboard DDR address mapper, between the core's 64-bit AXI memory master and the mapper's slave port.
- The mapper keeps only addr[27:0], so any address outside the 256 MB DRAM window would silently alias into DDR.
- This block forwards in-window transactions unchanged and terminates out-of-window ones locally with DECERR.
- It also counts the rejected transactions and records the most recent offending address for debug.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width.
- ID_WIDTH, 5, AXI ID width.
- WIN_TAG, 4'h8, required value of addr[31:28] for a transaction to be legal.
- MAX_OUTSTANDING, 15, per-direction limit on forwarded transactions (4-bit counters).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- s_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}  in  5/32/8/3/2/1/4/3/4/1  upstream write address.
- s_axi_awready  out  1
- s_axi_w{data,strb,last,valid}  in  64/8/1/1  upstream write data.
- s_axi_wready  out  1
- s_axi_b{id,resp,valid}  out  5/2/1  upstream write response.
- s_axi_bready  in  1
- s_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,valid}  in  same widths as AW  upstream read address.
- s_axi_arready  out  1
- s_axi_r{id,data,resp,last,valid}  out  5/64/2/1/1  upstream read data.
- s_axi_rready  in  1
- m_axi_*  mirror of s_axi_* with opposite directions  downstream port to the address mapper.
- decerr_cnt  out  16  saturating count of rejected transactions.
- last_bad_addr  out  32  address of the most recently rejected AW or AR.

Behaviour:
- Legality: an address is legal iff addr[31:28] == WIN_TAG. Legality is evaluated on the AW/AR payload while valid is high.
- Reset (async assert): both FSMs go to IDLE; counters, decerr_cnt and last_bad_addr go to 0. While reset is high, all s_*ready, m_*valid and s_*valid outputs are 0.
- Write FSM, states WR_IDLE, WR_PASS, WR_DRAIN, WR_RESP:
  - WR_IDLE, legal AW, wr_cnt < 15: AW forwarded combinationally (m_awvalid = s_awvalid, s_awready = m_awready). On handshake go to WR_PASS.
  - WR_IDLE, legal AW, wr_cnt == 15: s_awready = 0 and m_awvalid = 0 (stall).
  - WR_IDLE, illegal AW: stall until wr_cnt == 0. Then assert s_awready for 1 cycle, latch awid, update last_bad_addr and decerr_cnt, go to WR_DRAIN.
  - WR_PASS: W forwarded combinationally. On a W handshake with wlast, go to WR_IDLE.
  - W outside WR_PASS/WR_DRAIN: s_wready = 0 and m_wvalid = 0. AW must precede W.
  - WR_DRAIN: s_wready = 1 and beats are discarded. On a handshake with wlast, go to WR_RESP.
  - WR_RESP: s_bvalid = 1, bresp = 2'b11, bid = latched id, m_bready = 0. On bready go to WR_IDLE.
  - Outside WR_RESP, the B channel passes through combinationally.
- wr_cnt: +1 on m AW handshake, -1 on m B handshake; both in the same cycle leaves it unchanged.
- Read FSM, states RD_IDLE, RD_ERR:
  - RD_IDLE, legal AR: pass-through, gated by rd_cnt < 15.
  - RD_IDLE, illegal AR: wait for rd_cnt == 0. Then accept, latch arid, set beat counter = arlen, update debug outputs, go to RD_ERR.
  - RD_ERR: s_rvalid = 1, rdata = 0, rresp = 2'b11, rid = latched id, rlast = (beat counter == 0), m_rready = 0. Each rready handshake decrements the counter. The handshake with rlast returns to RD_IDLE. arlen = 255 yields exactly 256 beats.
  - Outside RD_ERR, the R channel passes through.
- rd_cnt: +1 on m AR handshake, -1 on m R handshake with rlast; simultaneous events net to zero.
- AW and AR are independent. If both are rejected in the same cycle, decerr_cnt += 2 and last_bad_addr takes the AR address.
- decerr_cnt saturates at 16'hFFFF.
- All pass-through payload fields are wired unchanged; there is no added latency on legal traffic.

Test Plan:
- Legal write, awaddr 0x8000_1000, len 3 → 4 beats appear on m_axi the same cycle; OKAY B from downstream returned with the original ID 5'h0A; decerr_cnt = 0.
- Illegal read, araddr 0x4000_0000, arlen 7, arid 3 → no m_arvalid; 8 R beats with rresp 2'b11, rdata 0, rid 3, rlast only on the 8th; decerr_cnt = 1; last_bad_addr = 0x4000_0000.
- Illegal write issued while 2 legal writes are outstanding → awready held 0 until both B responses return; then W drained (len 0) and a single DECERR B is returned.
- 15 legal ARs with m_rvalid held low → the 16th AR is stalled; it is accepted the cycle after one rlast returns.
- Simultaneous illegal AW (0x0000_0000) and AR (0x2000_0000) → decerr_cnt = 2; last_bad_addr = 0x2000_0000.
- Reset asserted mid-error burst (RD_ERR, 3 beats left) → s_rvalid drops immediately; after release, state is RD_IDLE and all counters are 0.
